decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 SHALL have parameter STACK_INIT, default 64'h0000_0000_0000_0200, reset value of register 4 (%rsp).
REQ-002 SHALL have parameter NREGS, default 15, number of architectural registers; ID 4'hF is RNONE.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset.
REQ-004 SHALL have ports: in_valid in 1; in_ready out 1; icode in 4; ifun in 4; rA in 4; rB in 4; valC in 64; valP in 64; iv in 1 (invalid instruction); ime in 1 (fetch address error).
REQ-005 SHALL have writeback ports: wb_e_en in 1; wb_dstE in 4; wb_valE in 64; wb_m_en in 1; wb_dstM in 4; wb_valM in 64.
REQ-006 SHALL have outputs: out_valid out 1; out_ready in 1; out_icode 4; out_ifun 4; out_valA 64; out_valB 64; out_valC 64; out_srcA 4; out_srcB 4; out_dstE 4; out_dstM 4; out_stat 2; halted out 1.
REQ-007 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-008 SHALL accept an instruction when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-009 SHALL register all out_* fields on acceptance; latency one cycle; out_valid held with stable fields until out_ready.
REQ-010 SHALL clear out_valid when out_ready is high and no new acceptance occurs that cycle.
REQ-011 srcA SHALL be rA for icode 2,4,6,10; 4 for 9,11; else RNONE.
REQ-012 srcB SHALL be rB for icode 4,5,6; 4 for 8,9,10,11; else RNONE.
REQ-013 dstE SHALL be rB for icode 2,3,6; 4 for 8,9,10,11; else RNONE. dstM SHALL be rA for 5,11; else RNONE.
REQ-014 valA SHALL be valP for icode 7,8; else regfile[srcA]; valB = regfile[srcB]; reads of RNONE return 0.
REQ-015 out_stat SHALL be ADR if ime, else INS if iv or icode>11, else HLT if icode==0, else AOK; ADR/INS force dstE=dstM=RNONE.
REQ-016 Non-AOK acceptance SHALL move state RUN->HALT; HALT drops in_ready, asserts halted, exits only on reset.
REQ-017 Regfile writes SHALL occur on clk edge: wb_e_en writes wb_valE to wb_dstE, wb_m_en writes wb_valM to wb_dstM; writes to RNONE ignored.
REQ-018 If both enables target the same register, wb_valM SHALL win.
REQ-019 Writeback SHALL continue in HALT state.

Reset
REQ-020 rst SHALL force state=RUN, out_valid=0, halted=0, all out_* fields 0 except dst/src = RNONE, out_stat=AOK.
REQ-021 rst SHALL clear all registers to 0 except register 4 = STACK_INIT; reset mid-transfer discards the held output.

Configuration
REQ-022 With DECODE_WB_BYPASS_EN defined, a read of a register written the same cycle SHALL return the incoming write value (valM priority).
REQ-023 Without DECODE_WB_BYPASS_EN, same-cycle reads SHALL return the pre-write value.

Structure
REQ-024 Package y86_pkg SHALL hold icode constants (IHALT..IPOPQ), RNONE, RRSP, and stat enum AOK/HLT/ADR/INS.
REQ-025 Register file SHALL be sub-module y86_regfile (two read ports, two write ports, bypass under macro).

Verification
REQ-026 Reset, then icode=3 rB=2 valC=5 accepted -> next cycle out_valid=1, out_dstE=2, out_valB=0, out_stat=AOK.
REQ-027 Write wb_dstE=2 valE=0x55, then icode=6 rA=2 rB=2 -> out_valA=out_valB=0x55.
REQ-028 icode=10 rA=1 -> out_srcB=4, out_dstE=4, out_valB=0x200; icode=8 valP=0x40 -> out_valA=0x40.
REQ-029 out_ready=0 with out_valid=1 -> in_ready=0, outputs stable 3 cycles; out_ready=1 -> next instruction accepted.
REQ-030 wb_dstE=wb_dstM=3, valE=1, valM=2, same-cycle read of r3: bypass build -> 2, else -> old value; afterwards r3=2.
REQ-031 iv=1 accepted -> out_stat=INS, dst=RNONE, halted=1, in_ready stays 0 until rst pulse.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: instruction codes, register IDs and the
// status codes carried alongside each decoded instruction.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] RRSP    = 4'h4;

   typedef enum logic [1:0] {
      AOK = 2'd0,
      HLT = 2'd1,
      ADR = 2'd2,
      INS = 2'd3
   } stat_e;

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational read ports, two write ports
// (M port wins on a collision). RNONE and out-of-range IDs read as 0 and
// ignore writes. Defining DECODE_WB_BYPASS_EN forwards same-cycle writes to
// the read ports; otherwise reads see the pre-write contents.
module y86_regfile
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
   parameter int          NREGS      = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   input  logic        e_en,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic        m_en,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m
);

   localparam logic [4:0] NREGS_W = 5'(NREGS);

   logic [63:0] regs [NREGS];

   function automatic logic is_reg(input logic [3:0] r);
      return (r != RNONE) && ({1'b0, r} < NREGS_W);
   endfunction

   // Register update; the M write is issued last so it overrides E on a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         regs[RRSP] <= STACK_INIT;
      end else begin
         if (e_en && is_reg(dst_e)) regs[dst_e] <= val_e;
         if (m_en && is_reg(dst_m)) regs[dst_m] <= val_m;
      end
   end

   // Read ports, with optional same-cycle forwarding (M over E).
   always_comb begin
      val_a = '0;
      val_b = '0;
      if (is_reg(src_a)) val_a = regs[src_a];
      if (is_reg(src_b)) val_b = regs[src_b];
`ifdef DECODE_WB_BYPASS_EN
      if (e_en && is_reg(src_a) && (dst_e == src_a)) val_a = val_e;
      if (m_en && is_reg(src_a) && (dst_m == src_a)) val_a = val_m;
      if (e_en && is_reg(src_b) && (dst_e == src_b)) val_b = val_e;
      if (m_en && is_reg(src_b) && (dst_m == src_b)) val_b = val_m;
`endif
   end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage. Decodes one instruction per handshake into a
// registered output slot, reads operands from y86_regfile and keeps applying
// writebacks even after halting. Optional macro: DECODE_WB_BYPASS_EN enables
// same-cycle write-to-read forwarding in the register file.
//
//   state  | meaning
//   RUN    | accepting instructions while the output slot can take them
//   HALT   | a non-AOK instruction was accepted; no further input until rst
module decode_writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
   parameter int          NREGS      = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic        iv,
   input  logic        ime,
   input  logic        wb_e_en,
   input  logic [3:0]  wb_dstE,
   input  logic [63:0] wb_valE,
   input  logic        wb_m_en,
   input  logic [3:0]  wb_dstM,
   input  logic [63:0] wb_valM,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_icode,
   output logic [3:0]  out_ifun,
   output logic [63:0] out_valA,
   output logic [63:0] out_valB,
   output logic [63:0] out_valC,
   output logic [3:0]  out_srcA,
   output logic [3:0]  out_srcB,
   output logic [3:0]  out_dstE,
   output logic [3:0]  out_dstM,
   output logic [1:0]  out_stat,
   output logic        halted
);

   typedef enum logic {S_RUN, S_HALT} state_e;

   state_e      state_q, state_d;
   logic [3:0]  src_a, src_b, dst_e, dst_m;
   stat_e       stat;
   logic [63:0] rd_a, rd_b, val_a;
   logic        accept;

   assign in_ready = (state_q == S_RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign halted   = (state_q == S_HALT);

   y86_regfile #(
      .STACK_INIT (STACK_INIT),
      .NREGS      (NREGS)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .src_a (src_a),
      .src_b (src_b),
      .val_a (rd_a),
      .val_b (rd_b),
      .e_en  (wb_e_en),
      .dst_e (wb_dstE),
      .val_e (wb_valE),
      .m_en  (wb_m_en),
      .dst_m (wb_dstM),
      .val_m (wb_valM)
   );

   // Operand selection, destinations and status for the presented instruction.
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      stat  = AOK;

      case (icode)
         IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = rA;
         IRET, IPOPQ:                    src_a = RRSP;
         default:                        src_a = RNONE;
      endcase

      case (icode)
         IRMMOVQ, IMRMOVQ, IOPQ:         src_b = rB;
         ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RRSP;
         default:                        src_b = RNONE;
      endcase

      case (icode)
         IRRMOVQ, IIRMOVQ, IOPQ:         dst_e = rB;
         ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RRSP;
         default:                        dst_e = RNONE;
      endcase

      case (icode)
         IMRMOVQ, IPOPQ:                 dst_m = rA;
         default:                        dst_m = RNONE;
      endcase

      if (ime)                          stat = ADR;
      else if (iv || (icode > IPOPQ))   stat = INS;
      else if (icode == IHALT)          stat = HLT;

      // Faulting instructions must not retire any register update.
      if ((stat == ADR) || (stat == INS)) begin
         dst_e = RNONE;
         dst_m = RNONE;
      end
   end

   // Jumps and calls carry the fall-through PC in valA instead of a register.
   assign val_a = ((icode == IJXX) || (icode == ICALL)) ? valP : rd_a;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RUN;
      else     state_q <= state_d;
   end

   // FSM next state: any non-AOK acceptance parks the stage in HALT.
   always_comb begin
      state_d = state_q;
      if ((state_q == S_RUN) && accept && (stat != AOK)) state_d = S_HALT;
   end

   // Output slot: load on acceptance, drain on out_ready, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_icode <= '0;
         out_ifun  <= '0;
         out_valA  <= '0;
         out_valB  <= '0;
         out_valC  <= '0;
         out_srcA  <= RNONE;
         out_srcB  <= RNONE;
         out_dstE  <= RNONE;
         out_dstM  <= RNONE;
         out_stat  <= AOK;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_icode <= icode;
         out_ifun  <= ifun;
         out_valA  <= val_a;
         out_valB  <= rd_b;
         out_valC  <= valC;
         out_srcA  <= src_a;
         out_srcB  <= src_b;
         out_dstE  <= dst_e;
         out_dstM  <= dst_m;
         out_stat  <= stat;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: a cycle-level reference model (register array,
// output slot, halt flag) checks every cycle; a vector table covers the fixed
// decode cases, followed by random traffic and hand-written corner sequences.
module tb_decode_writeback;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic        iv, ime;
   logic        wb_e_en, wb_m_en;
   logic [3:0]  wb_dstE, wb_dstM;
   logic [63:0] wb_valE, wb_valM;
   logic        out_valid, out_ready;
   logic [3:0]  out_icode, out_ifun, out_srcA, out_srcB, out_dstE, out_dstM;
   logic [63:0] out_valA, out_valB, out_valC;
   logic [1:0]  out_stat;
   logic        halted;

   always #5 clk = ~clk;

   decode_writeback dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .iv(iv), .ime(ime),
      .wb_e_en(wb_e_en), .wb_dstE(wb_dstE), .wb_valE(wb_valE),
      .wb_m_en(wb_m_en), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_icode(out_icode), .out_ifun(out_ifun),
      .out_valA(out_valA), .out_valB(out_valB), .out_valC(out_valC),
      .out_srcA(out_srcA), .out_srcB(out_srcB),
      .out_dstE(out_dstE), .out_dstM(out_dstM),
      .out_stat(out_stat), .halted(halted)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] mregs [16];
   bit          m_valid, m_halted;
   logic [3:0]  m_icode, m_ifun, m_srcA, m_srcB, m_dstE, m_dstM;
   logic [63:0] m_valA, m_valB, m_valC;
   logic [1:0]  m_stat;

   function automatic logic [63:0] mread(input logic [3:0] r);
      if (r == 4'hF) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_m_en && wb_dstM == r) return wb_valM;
      if (wb_e_en && wb_dstE == r) return wb_valE;
`endif
      return mregs[r];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mregs[i] = 64'd0;
      mregs[4] = 64'h200;
      m_valid = 0; m_halted = 0;
      m_icode = 0; m_ifun = 0; m_valA = 0; m_valB = 0; m_valC = 0;
      m_srcA = 4'hF; m_srcB = 4'hF; m_dstE = 4'hF; m_dstM = 4'hF; m_stat = 2'd0;
   endtask

   // One clock: predict from current inputs, advance, update model, compare.
   task automatic cycle();
      bit rdy, acc;
      logic [3:0]  n_srcA, n_srcB, n_dstE, n_dstM;
      logic [1:0]  n_stat;
      logic [63:0] n_valA, n_valB;
      #1;
      rdy = !m_halted && (!m_valid || out_ready);
      chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      acc = in_valid && rdy;
      n_srcA = (icode inside {4'd2, 4'd4, 4'd6, 4'd10}) ? rA :
               (icode inside {4'd9, 4'd11}) ? 4'd4 : 4'hF;
      n_srcB = (icode inside {4'd4, 4'd5, 4'd6}) ? rB :
               (icode inside {4'd8, 4'd9, 4'd10, 4'd11}) ? 4'd4 : 4'hF;
      n_dstE = (icode inside {4'd2, 4'd3, 4'd6}) ? rB :
               (icode inside {4'd8, 4'd9, 4'd10, 4'd11}) ? 4'd4 : 4'hF;
      n_dstM = (icode inside {4'd5, 4'd11}) ? rA : 4'hF;
      if (ime)                     n_stat = 2'd2;
      else if (iv || icode > 4'd11) n_stat = 2'd3;
      else if (icode == 4'd0)      n_stat = 2'd1;
      else                         n_stat = 2'd0;
      if (n_stat >= 2'd2) begin n_dstE = 4'hF; n_dstM = 4'hF; end
      n_valA = (icode inside {4'd7, 4'd8}) ? valP : mread(n_srcA);
      n_valB = mread(n_srcB);

      @(posedge clk); #1;

      if (wb_e_en && wb_dstE != 4'hF) mregs[wb_dstE] = wb_valE;
      if (wb_m_en && wb_dstM != 4'hF) mregs[wb_dstM] = wb_valM;
      if (acc) begin
         m_valid = 1;
         m_icode = icode; m_ifun = ifun; m_valC = valC;
         m_srcA = n_srcA; m_srcB = n_srcB; m_dstE = n_dstE; m_dstM = n_dstM;
         m_valA = n_valA; m_valB = n_valB; m_stat = n_stat;
         if (n_stat != 2'd0) m_halted = 1;
      end else if (out_ready) begin
         m_valid = 0;
      end

      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("halted", {63'd0, halted}, {63'd0, m_halted});
      if (m_valid) begin
         chk("out_icode", {60'd0, out_icode}, {60'd0, m_icode});
         chk("out_ifun",  {60'd0, out_ifun},  {60'd0, m_ifun});
         chk("out_valA",  out_valA, m_valA);
         chk("out_valB",  out_valB, m_valB);
         chk("out_valC",  out_valC, m_valC);
         chk("out_srcA",  {60'd0, out_srcA},  {60'd0, m_srcA});
         chk("out_srcB",  {60'd0, out_srcB},  {60'd0, m_srcB});
         chk("out_dstE",  {60'd0, out_dstE},  {60'd0, m_dstE});
         chk("out_dstM",  {60'd0, out_dstM},  {60'd0, m_dstM});
         chk("out_stat",  {62'd0, out_stat},  {62'd0, m_stat});
      end
   endtask

   task automatic idle_inputs();
      in_valid = 0; icode = 4'd1; ifun = 0; rA = 4'hF; rB = 4'hF;
      valC = 0; valP = 0; iv = 0; ime = 0;
      wb_e_en = 0; wb_dstE = 4'hF; wb_valE = 0;
      wb_m_en = 0; wb_dstM = 4'hF; wb_valM = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      model_reset();
      #2;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_halted",    {63'd0, halted}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
      chk("rst_srcA",      {60'd0, out_srcA}, 64'hF);
      chk("rst_dstM",      {60'd0, out_dstM}, 64'hF);
      chk("rst_stat",      {62'd0, out_stat}, 64'd0);
      chk("rst_valA",      out_valA, 64'd0);
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic issue(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] c, input logic [63:0] p);
      in_valid = 1; icode = ic; ifun = 4'd0; rA = a; rB = b; valC = c; valP = p;
      cycle();
      in_valid = 0;
   endtask

   typedef struct {
      logic [3:0]  icode, rA, rB;
      logic [63:0] valP;
      logic [3:0]  e_srcA, e_srcB, e_dstE, e_dstM;
      logic [63:0] e_valA, e_valB;
   } vec_t;

   vec_t tbl [9];

   initial begin
      // icode, rA, rB, valP | srcA, srcB, dstE, dstM, valA, valB  (fresh reset state)
      tbl[0] = '{4'd3,  4'hF, 4'd2, 64'h10, 4'hF, 4'hF, 4'd2, 4'hF, 64'h0,   64'h0};
      tbl[1] = '{4'd10, 4'd1, 4'hF, 64'h12, 4'd1, 4'd4, 4'd4, 4'hF, 64'h0,   64'h200};
      tbl[2] = '{4'd8,  4'hF, 4'hF, 64'h40, 4'hF, 4'd4, 4'd4, 4'hF, 64'h40,  64'h200};
      tbl[3] = '{4'd11, 4'd3, 4'hF, 64'h14, 4'd4, 4'd4, 4'd4, 4'd3, 64'h200, 64'h200};
      tbl[4] = '{4'd9,  4'hF, 4'hF, 64'h15, 4'd4, 4'd4, 4'd4, 4'hF, 64'h200, 64'h200};
      tbl[5] = '{4'd5,  4'd6, 4'd4, 64'h16, 4'hF, 4'd4, 4'hF, 4'd6, 64'h0,   64'h200};
      tbl[6] = '{4'd7,  4'hF, 4'hF, 64'h77, 4'hF, 4'hF, 4'hF, 4'hF, 64'h77,  64'h0};
      tbl[7] = '{4'd1,  4'hF, 4'hF, 64'h18, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
      tbl[8] = '{4'd4,  4'd4, 4'd4, 64'h19, 4'd4, 4'd4, 4'hF, 4'hF, 64'h200, 64'h200};

      out_ready = 1;
      do_reset();

      // Fixed decode vectors against hand-derived expectations.
      for (int i = 0; i < 9; i++) begin
         issue(tbl[i].icode, tbl[i].rA, tbl[i].rB, 64'h100 + 64'(i), tbl[i].valP);
         chk($sformatf("tbl%0d_srcA", i), {60'd0, out_srcA}, {60'd0, tbl[i].e_srcA});
         chk($sformatf("tbl%0d_srcB", i), {60'd0, out_srcB}, {60'd0, tbl[i].e_srcB});
         chk($sformatf("tbl%0d_dstE", i), {60'd0, out_dstE}, {60'd0, tbl[i].e_dstE});
         chk($sformatf("tbl%0d_dstM", i), {60'd0, out_dstM}, {60'd0, tbl[i].e_dstM});
         chk($sformatf("tbl%0d_valA", i), out_valA, tbl[i].e_valA);
         chk($sformatf("tbl%0d_valB", i), out_valB, tbl[i].e_valB);
         chk($sformatf("tbl%0d_valC", i), out_valC, 64'h100 + 64'(i));
         chk($sformatf("tbl%0d_stat", i), {62'd0, out_stat}, 64'd0);
      end

      // Write r2 then read it through both ports.
      wb_e_en = 1; wb_dstE = 4'd2; wb_valE = 64'h55;
      cycle();
      wb_e_en = 0;
      issue(4'd6, 4'd2, 4'd2, 64'd0, 64'd0);
      chk("opq_valA", out_valA, 64'h55);
      chk("opq_valB", out_valB, 64'h55);

      // Random traffic: backpressure, writebacks, non-halting instructions.
      for (int n = 0; n < 400; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         icode     = 4'($urandom_range(1, 11));
         ifun      = 4'($urandom_range(0, 15));
         rA        = 4'($urandom_range(0, 15));
         rB        = 4'($urandom_range(0, 15));
         valC      = {$urandom, $urandom};
         valP      = {$urandom, $urandom};
         wb_e_en   = 1'($urandom_range(0, 1));
         wb_dstE   = 4'($urandom_range(0, 15));
         wb_valE   = {$urandom, $urandom};
         wb_m_en   = 1'($urandom_range(0, 1));
         wb_dstM   = (n % 5 == 0) ? wb_dstE : 4'($urandom_range(0, 15));
         wb_valM   = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      idle_inputs();
      out_ready = 1;
      cycle();

      // Backpressure: held output must not move for 3 cycles.
      out_ready = 0;
      issue(4'd3, 4'hF, 4'd7, 64'hAAAA, 64'd0);
      in_valid = 1; icode = 4'd2; rA = 4'd4; rB = 4'd5; valC = 64'hBBBB;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_valC_hold", out_valC, 64'hAAAA);
      end
      out_ready = 1;
      cycle();
      chk("bp_next_valC", out_valC, 64'hBBBB);
      in_valid = 0;
      cycle();

      // Same-register collision on both write ports with a concurrent read.
      wb_e_en = 1; wb_dstE = 4'd3; wb_valE = 64'd1;
      wb_m_en = 1; wb_dstM = 4'd3; wb_valM = 64'd2;
      issue(4'd6, 4'd3, 4'd3, 64'd0, 64'd0);
      wb_e_en = 0; wb_m_en = 0;
      issue(4'd6, 4'd3, 4'd3, 64'd0, 64'd0);
      chk("collide_r3", out_valA, 64'd2);

      // Reset while an output is being held discards it.
      out_ready = 0;
      issue(4'd1, 4'hF, 4'hF, 64'd9, 64'd0);
      do_reset();
      out_ready = 1;

      // Invalid instruction halts until reset.
      iv = 1;
      issue(4'd3, 4'hF, 4'd2, 64'd1, 64'd0);
      iv = 0;
      chk("iv_stat", {62'd0, out_stat}, 64'd3);
      chk("iv_dstE", {60'd0, out_dstE}, 64'hF);
      in_valid = 1; icode = 4'd1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("halt_in_ready", {63'd0, in_ready}, 64'd0);
      end
      do_reset();

      // Fetch address error and plain halt.
      ime = 1;
      issue(4'd11, 4'd3, 4'hF, 64'd0, 64'd0);
      ime = 0;
      chk("ime_stat", {62'd0, out_stat}, 64'd2);
      chk("ime_dstM", {60'd0, out_dstM}, 64'hF);
      do_reset();
      issue(4'd0, 4'hF, 4'hF, 64'd0, 64'd0);
      chk("hlt_stat", {62'd0, out_stat}, 64'd1);
      chk("hlt_halted", {63'd0, halted}, 64'd1);
      do_reset();
      issue(4'd12, 4'd1, 4'd2, 64'd0, 64'd0);
      chk("badop_stat", {62'd0, out_stat}, 64'd3);
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
